// File: rtl/alu_multicycle_exec.sv
// alu_multicycle_exec
//   Execute-stage ALU driven by the 3-bit ALUControl code from the ALU decoder.
//   Add and sub finish in one cycle. Mul (shift-add) and unsigned div
//   (restoring) iterate one bit per cycle. The start/busy/done handshake lets
//   pipeline control stall while a mul or div is in flight.
//
//   Optional feature macro: ALU_FAST_MUL_EN
//     When defined, mul uses a single-cycle WIDTHxWIDTH multiplier and goes
//     through EXEC (latency 1). When undefined, mul uses the iterative path
//     (latency WIDTH+1) and no hard multiplier is inferred.
//
// Ports
//   clk, rst     rising-edge clock; asynchronous active-high reset
//   start        request, accepted only while busy=0
//   ALUControl   000 add, 001 sub, 010 mul, 011 div; any other code adds
//   SrcA, SrcB   operands (dividend, divisor); captured on the accept edge
//   busy         an operation is in progress
//   done         one-cycle pulse: result, flags and DivZero are valid
//   ALUResult    sum, difference, low product or quotient
//   Remainder    div remainder; 0 for every other op
//   Flags        {N,Z,C,V} of ALUResult
//   DivZero      set together with done for a div whose SrcB was 0
module alu_multicycle_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] Remainder,
  output logic [3:0]       Flags,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DIV} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Shared iteration register. mul: {high partial product, remaining
  // multiplier bits}. div: {partial remainder, dividend/quotient bits}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [3:0]       flags_q, flags_d;
  logic             dz_q, dz_d;

  // One-cycle arithmetic on the captured operands.
  logic [WIDTH:0]   add_sum, sub_sum;
  logic             add_v, sub_v;
  assign add_sum = {1'b0, a_q} + {1'b0, b_q};
  assign sub_sum = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
  assign add_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
  assign sub_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_sum[WIDTH-1] != a_q[WIDTH-1]);

  // Shift-add step: add the multiplicand into the high half when the low
  // multiplier bit is set, then shift the whole register right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: shift the next dividend bit into the remainder and trial
  // subtract. The remainder stays below the divisor, so it fits in WIDTH+1
  // bits and the MSB of the trial is the borrow.
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
  assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

`ifdef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`endif

  logic             fin;
  logic [WIDTH-1:0] fin_res, fin_rem;
  logic             fin_c, fin_v, fin_dz;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    result_d = result_q;
    rem_d    = rem_q;
    flags_d  = flags_q;
    dz_d     = dz_q;
    fin      = 1'b0;
    fin_res  = '0;
    fin_rem  = '0;
    fin_c    = 1'b0;
    fin_v    = 1'b0;
    fin_dz   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = ALUControl;
          a_d   = SrcA;
          b_d   = SrcB;
          acc_d = {{WIDTH{1'b0}}, SrcA};
          cnt_d = CW'(WIDTH);
          case (ALUControl)
`ifdef ALU_FAST_MUL_EN
            OP_MUL:  state_d = EXEC;
`else
            OP_MUL:  state_d = MUL;
`endif
            // Divide by zero resolves in EXEC without iterating.
            OP_DIV:  state_d = (SrcB == '0) ? EXEC : DIV;
            default: state_d = EXEC;
          endcase
        end
      end
      EXEC: begin
        fin     = 1'b1;
        state_d = IDLE;
        case (op_q)
          OP_SUB: begin
            fin_res = sub_sum[WIDTH-1:0];
            fin_c   = sub_sum[WIDTH];
            fin_v   = sub_v;
          end
          OP_DIV: begin
            fin_res = '1;
            fin_rem = a_q;
            fin_dz  = 1'b1;
          end
`ifdef ALU_FAST_MUL_EN
          OP_MUL: begin
            fin_res = fast_prod[WIDTH-1:0];
            fin_c   = |fast_prod[2*WIDTH-1:WIDTH];
          end
`endif
          default: begin
            fin_res = add_sum[WIDTH-1:0];
            fin_c   = add_sum[WIDTH];
            fin_v   = add_v;
          end
        endcase
      end
      MUL: begin
        if (cnt_q != '0) begin
          acc_d = mul_next;
          cnt_d = cnt_q - CW'(1);
        end else begin
          fin     = 1'b1;
          state_d = IDLE;
          fin_res = acc_q[WIDTH-1:0];
          fin_c   = |acc_q[2*WIDTH-1:WIDTH];
        end
      end
      DIV: begin
        if (cnt_q != '0) begin
          acc_d = div_next;
          cnt_d = cnt_q - CW'(1);
        end else begin
          fin     = 1'b1;
          state_d = IDLE;
          fin_res = acc_q[WIDTH-1:0];
          fin_rem = acc_q[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = IDLE;
    endcase

    // Result registers change only on completion, so they hold from one
    // done to the next.
    if (fin) begin
      done_d   = 1'b1;
      result_d = fin_res;
      rem_d    = fin_rem;
      dz_d     = fin_dz;
      flags_d  = {fin_res[WIDTH-1], (fin_res == '0), fin_c, fin_v};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      flags_q  <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      flags_q  <= flags_d;
      dz_q     <= dz_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign ALUResult = result_q;
  assign Remainder = rem_q;
  assign Flags     = flags_q;
  assign DivZero   = dz_q;

endmodule
